muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit sitting directly downstream of the register file.
- Consumes the two read operands (rd1/rd2) plus funct3 and destination index of an M-extension instruction.
- Produces a 32-bit result with a one-cycle write strobe that feeds the register file's wr_data/reg_wr inputs.
- Multi-cycle, shift-add / restoring-division datapath; one operation in flight.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  32  rs1 value (from rd1)
- op_b  in  32  rs2 value (from rd2)
- rd_in  in  5  destination register index
- kill  in  1  abandon current operation (pipeline flush)
- busy  out  1  operation in progress
- done  out  1  one-cycle result-valid pulse
- result  out  32  wr_data to register file
- rd_out  out  5  destination index for result
- reg_wr  out  1  write strobe = done AND rd_out != 0

Behaviour:
- Reset (async, any time, including mid-operation):
  - State goes to IDLE; busy=0, done=0, reg_wr=0, result=0, rd_out=0, counter=0.
  - The in-flight operation is discarded.
- States:
  - IDLE: wait for start.
  - PREP: capture operands, take magnitudes of signed operands, detect special cases.
  - CALC: 32 iterations, one per clock.
  - FIN: apply sign correction, select high/low word or quotient/remainder, register outputs.
- Start handshake:
  - start is sampled in IDLE at edge k; op_a, op_b, funct3 and rd_in are latched at that edge.
  - Inputs may change afterwards without effect.
  - start while busy=1 is ignored; no queueing.
- Latency, iterative ops:
  - busy=1 from edge k+1.
  - done=1 for exactly one cycle, starting at edge k+35.
  - busy falls at that same edge.
- Latency, special cases (bypass CALC):
  - Cases: divide by zero; signed overflow 0x80000000 / 0xFFFFFFFF.
  - done rises at edge k+3.
- A new start is accepted in the done cycle (back-to-back issue).
- Signedness:
  - MULH and DIV/REM treat both operands as signed.
  - MULHSU treats op_a as signed and op_b as unsigned.
  - MULHU, DIVU and REMU are unsigned.
- Results:
  - MUL returns the low 32 bits of the 64-bit product.
  - MULH/MULHSU/MULHU return the high 32 bits.
  - Product sign = XOR of operand signs (unsigned operand counts as positive).
  - Quotient sign = XOR of operand signs; remainder sign = dividend sign.
  - Division truncates toward zero.
- Divide by zero:
  - DIV/DIVU return 0xFFFFFFFF.
  - REM/REMU return op_a unchanged.
- Signed overflow: DIV returns 0x80000000; REM returns 0.
- Output timing:
  - result, rd_out and done are registered and held stable for the full done cycle.
  - The register file writes on the falling edge inside that cycle.
  - result and rd_out hold their last value after done falls.
- rd_in=0: the operation completes and done pulses, but reg_wr stays 0.
- kill:
  - Any state other than IDLE returns to IDLE at the next edge; no done or reg_wr is produced.
  - kill in IDLE has no effect.
  - kill with start in the same cycle: kill wins and the start is dropped.
- Counter:
  - Counts 0..31 in CALC; leaves CALC when count=31.
  - No wrap-around into a second pass.

Test Plan:
- MUL, op_a=7, op_b=10, rd_in=3 -> done at start+35 with result=0x00000046, rd_out=3, reg_wr=1 for one cycle; busy high the 34 cycles before.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU op_a=0xFFFFFFFF, op_b=2 -> 0xFFFFFFFF; MUL op_a=0x80000000, op_b=2 -> 0x00000000.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each done at start+3:
  - DIVU x/0 -> 0xFFFFFFFF.
  - REMU 0x1234/0 -> 0x1234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- rd_in=0 MUL -> done=1, reg_wr=0. Start pulsed mid-operation with different operands -> ignored, first result unchanged. Second start in the done cycle -> next done 35 cycles later.
- kill asserted at CALC count=10 -> IDLE, no done. rst asserted mid-CALC asynchronously -> all outputs 0 immediately. New start after either -> correct result at the normal latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: shift-add multiply, restoring divide, one op in flight.
// Done 35 edges after start (3 for div-by-zero/overflow); start ignored while an op is in flight.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_wr
);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fin_ph_q, fin_ph_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic              neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic              special_q, special_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              reg_wr_q, reg_wr_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  logic              is_div, a_sgn, b_sgn, neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf;
  logic [XLEN:0]     sum, rem_sh, diff;
  logic [2*XLEN-1:0] prod_neg;

  always_comb begin
    is_div   = f3_q[2];
    a_sgn    = (f3_q == 3'b001) || (f3_q == 3'b010) || (f3_q == 3'b100) || (f3_q == 3'b110);
    b_sgn    = (f3_q == 3'b001) || (f3_q == 3'b100) || (f3_q == 3'b110);
    neg_a    = a_sgn && a_q[XLEN-1];
    neg_b    = b_sgn && b_q[XLEN-1];
    mag_a    = neg_a ? (~a_q + 1'b1) : a_q;
    mag_b    = neg_b ? (~b_q + 1'b1) : b_q;
    div_zero = is_div && (b_q == '0);
    div_ovf  = is_div && !f3_q[0] && (a_q == MIN_INT) && (b_q == '1);

    // multiply step: conditional add of the multiplicand, then shift {carry,hi,lo} right
    sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    // divide step: shift remainder left pulling in the next dividend bit, trial subtract
    rem_sh   = {hi_q, lo_q[XLEN-1]};
    diff     = rem_sh - {1'b0, m_q};
    prod_neg = ~{hi_q, lo_q} + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    fin_ph_d  = fin_ph_q;
    a_d       = a_q;
    b_d       = b_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    m_d       = m_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    special_d = special_q;
    done_d    = 1'b0;
    reg_wr_d  = 1'b0;
    result_d  = result_q;
    rd_out_d  = rd_out_q;

    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_d     = op_a;
            b_d     = op_b;
            f3_d    = funct3;
            rd_d    = rd_in;
            state_d = PREP;
          end
        end
        PREP: begin
          fin_ph_d  = 1'b0;
          special_d = div_zero || div_ovf;
          hi_d      = '0;
          neg_lo_d  = neg_a ^ neg_b;
          neg_hi_d  = neg_a;
          if (div_zero) begin
            lo_d    = f3_q[1] ? a_q : '1;
            state_d = FIN;
          end else if (div_ovf) begin
            lo_d    = f3_q[1] ? '0 : MIN_INT;
            state_d = FIN;
          end else begin
            lo_d    = is_div ? mag_a : mag_b;
            m_d     = is_div ? mag_b : mag_a;
            state_d = CALC;
          end
        end
        CALC: begin
          if (is_div) begin
            if (!diff[XLEN]) begin
              hi_d = diff[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = rem_sh[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == CNT_W'(XLEN-1)) begin
            fin_ph_d = 1'b0;
            state_d  = FIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        FIN: begin
          if (!fin_ph_q) begin
            fin_ph_d = 1'b1;
            if (!special_q) begin
              if (!is_div) begin
                if (neg_lo_q) {hi_d, lo_d} = prod_neg;
              end else begin
                if (neg_lo_q) lo_d = ~lo_q + 1'b1;
                if (neg_hi_q) hi_d = ~hi_q + 1'b1;
              end
            end
          end else begin
            if (special_q)           result_d = lo_q;
            else if (is_div)         result_d = f3_q[1] ? hi_q : lo_q;
            else if (f3_q == 3'b000) result_d = lo_q;
            else                     result_d = hi_q;
            rd_out_d = rd_q;
            done_d   = 1'b1;
            reg_wr_d = (rd_q != 5'd0);
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_q != IDLE) && (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      fin_ph_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= 3'b000;
      rd_q      <= 5'd0;
      hi_q      <= '0;
      lo_q      <= '0;
      m_q       <= '0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      special_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      reg_wr_q  <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fin_ph_q  <= fin_ph_d;
      a_q       <= a_d;
      b_q       <= b_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      m_q       <= m_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      special_q <= special_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      reg_wr_q  <= reg_wr_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign reg_wr = reg_wr_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, multi-cycle corner sequences, random ops vs model.
module tb_muldiv_unit;

  logic        clk, rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, reg_wr;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .rd_in(rd_in), .kill(kill), .busy(busy), .done(done), .result(result),
    .rd_out(rd_out), .reg_wr(reg_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * $signed(ub); return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 32'd0)) return 3;
    if (f3[2] && !f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 3;
    return 35;
  endfunction

  // Issues one op, then returns #1 after the edge on which done is seen (inside the done cycle).
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                        input int exp_lat, input bit poke);
    int lat;
    int busy_cnt;
    lat      = 0;
    busy_cnt = 0;
    start  = 1'b1;
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    @(posedge clk);
    #1;
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    funct3 = 3'($urandom_range(0, 7));
    rd_in  = 5'($urandom_range(0, 31));
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      start = poke && (n == 10);
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy cycles"}, busy_cnt, exp_lat - 1);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
    chk({tag, " reg_wr"}, {31'd0, reg_wr}, {31'd0, (rd != 5'd0)});
    chk({tag, " busy at done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (done || reg_wr || busy) seen++;
    end
    chk({tag, " quiet cycles"}, seen, 0);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;

    tbl[0]  = '{3'b000, 32'd7,          32'd10,         5'd3,  32'h0000_0046, 35};
    tbl[1]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5,  32'hFFFF_FFFE, 35};
    tbl[2]  = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'h0000_0000, 35};
    tbl[3]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,          5'd7,  32'hFFFF_FFFF, 35};
    tbl[4]  = '{3'b000, 32'h8000_0000,  32'd2,          5'd8,  32'h0000_0000, 35};
    tbl[5]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd9,  32'hFFFF_FFFD, 35};
    tbl[6]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd10, 32'hFFFF_FFFF, 35};
    tbl[7]  = '{3'b101, 32'd100,        32'd7,          5'd11, 32'd14,        35};
    tbl[8]  = '{3'b111, 32'd100,        32'd7,          5'd12, 32'd2,         35};
    tbl[9]  = '{3'b101, 32'h0000_0055,  32'd0,          5'd13, 32'hFFFF_FFFF, 3};
    tbl[10] = '{3'b111, 32'h0000_1234,  32'd0,          5'd14, 32'h0000_1234, 3};
    tbl[11] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'h8000_0000, 3};
    tbl[12] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h0000_0000, 3};
    tbl[13] = '{3'b000, 32'd7,          32'd10,         5'd0,  32'h0000_0046, 35};
    tbl[14] = '{3'b100, 32'd5,          32'd0,          5'd17, 32'hFFFF_FFFF, 3};
    tbl[15] = '{3'b110, 32'hFFFF_FFF9,  32'd0,          5'd18, 32'hFFFF_FFF9, 3};

    rst = 1'b1; start = 1'b0; kill = 1'b0;
    funct3 = 3'b000; op_a = '0; op_b = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy",   {31'd0, busy},   32'd0);
    chk("reset done",   {31'd0, done},   32'd0);
    chk("reset reg_wr", {31'd0, reg_wr}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd_out", {27'd0, rd_out}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd,
             tbl[i].res, tbl[i].lat, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d done width", i), {31'd0, done}, 32'd0);
      chk($sformatf("vec%0d result hold", i), result, tbl[i].res);
    end

    // start pulsed mid-operation with other operands is ignored
    run_op("poke", 3'b101, 32'd1000, 32'd33, 5'd4, 32'd30, 35, 1'b1);
    // back-to-back issue from the done cycle
    run_op("b2b", 3'b111, 32'd1000, 32'd33, 5'd21, 32'd10, 35, 1'b0);
    @(posedge clk);
    #1;

    // kill at CALC count 10
    start = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill busy", {31'd0, busy}, 32'd0);
    watch_quiet("kill", 40);
    run_op("after kill", 3'b000, 32'd7, 32'd10, 5'd3, 32'h0000_0046, 35, 1'b0);
    @(posedge clk);
    #1;

    // kill together with start in idle drops the start
    start = 1'b1; kill = 1'b1; funct3 = 3'b101; op_a = 32'd50; op_b = 32'd5; rd_in = 5'd6;
    @(posedge clk);
    #1;
    start = 1'b0; kill = 1'b0;
    watch_quiet("kill+start", 40);

    // asynchronous reset mid-CALC
    start = 1'b1; funct3 = 3'b011; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; rd_in = 5'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst busy",   {31'd0, busy},   32'd0);
    chk("async rst result", result, 32'd0);
    chk("async rst rd_out", {27'd0, rd_out}, 32'd0);
    chk("async rst done",   {31'd0, done},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_quiet("after rst", 40);
    run_op("after rst", 3'b100, 32'hFFFF_FF9C, 32'd7, 5'd19, 32'hFFFF_FFF2, 35, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      rrd = 5'($urandom_range(0, 31));
      run_op($sformatf("rand%0d", i), rf3, ra, rb, rrd, ref_res(rf3, ra, rb),
             ref_lat(rf3, ra, rb), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
